hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the IF/ID/EX front end; drives the enables and flushes of the PC, the IF/ID register and the ID/EX register built by the decode stage.
- Detects load-use hazards against the decoding instruction and applies taken-branch flushes with a configurable penalty.
- Freezes the whole front end while instruction or data memory is not ready.
- Keeps stall and flush performance counters.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/sat_counter.sv | 18 +
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end pipeline types: hazard controller states and widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         PENALTY_W = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX hazard inputs, memory status, stage controls, counters.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             imem_req;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
           ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_req, imem_ready, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           stall_cnt, flush_cnt
  );

  modport master (
    output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
           ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_req, imem_ready, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 q <= '0;
    else if (clear)           q <= '0;
    else if (inc && q != '1)  q <= q + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID/EX sequencing: memory freeze, taken-branch flush window, load-use bubble.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hif
);

  localparam logic [PENALTY_W-1:0] BR_RELOAD = PENALTY_W'(BR_FLUSH_CYCLES - 1);

  hz_state_e            state, nxt_state, ret_state, nxt_ret;
  hz_state_e            eff_state;
  logic [PENALTY_W-1:0] cnt, nxt_cnt;
  logic                 mem_busy, lu_hazard;
  logic                 pc_en_r, ifid_en_r, ifid_flush_r, idex_en_r, idex_flush_r;

  assign mem_busy  = (hif.imem_req & ~hif.imem_ready) | (hif.dmem_req & ~hif.dmem_ready);
  assign lu_hazard = hif.ex_mem_read & (hif.ex_rd_addr != REG_ZERO) &
                     ((hif.id_use_rs1 & (hif.ex_rd_addr == hif.id_rs1_addr)) |
                      (hif.id_use_rs2 & (hif.ex_rd_addr == hif.id_rs2_addr)));

  // cnt is frozen while busy, so it doubles as the saved flush count in MEM_WAIT.
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
      cnt       <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_ret      = ret_state;
    nxt_cnt      = cnt;
    pc_en_r      = 1'b0;
    ifid_en_r    = 1'b0;
    ifid_flush_r = 1'b0;
    idex_en_r    = 1'b0;
    idex_flush_r = 1'b0;
    if (mem_busy) begin
      if (state != MEM_WAIT) begin
        nxt_ret   = state;
        nxt_state = MEM_WAIT;
      end
    end else begin
      unique case (eff_state)
        BR_FLUSH: begin
          pc_en_r      = 1'b1;
          ifid_en_r    = 1'b1;
          ifid_flush_r = 1'b1;
          idex_en_r    = 1'b1;
          idex_flush_r = 1'b1;
          nxt_cnt      = cnt - PENALTY_W'(1);
          nxt_state    = (cnt <= PENALTY_W'(1)) ? RUN : BR_FLUSH;
        end
        default: begin
          nxt_state = RUN;
          if (hif.ex_branch_taken) begin
            pc_en_r      = 1'b1;
            ifid_en_r    = 1'b1;
            ifid_flush_r = 1'b1;
            idex_en_r    = 1'b1;
            idex_flush_r = 1'b1;
            if (BR_FLUSH_CYCLES > 1) begin
              nxt_cnt   = BR_RELOAD;
              nxt_state = BR_FLUSH;
            end
          end else if (lu_hazard) begin
            idex_en_r    = 1'b1;
            idex_flush_r = 1'b1;
          end else begin
            pc_en_r   = 1'b1;
            ifid_en_r = 1'b1;
            idex_en_r = 1'b1;
          end
        end
      endcase
    end
  end

  // Reset state is RUN, whose normal decode would enable everything; gate with rst.
  assign hif.pc_en      = rst & pc_en_r;
  assign hif.ifid_en    = rst & ifid_en_r;
  assign hif.ifid_flush = rst & ifid_flush_r;
  assign hif.idex_en    = rst & idex_en_r;
  assign hif.idex_flush = rst & idex_flush_r;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~hif.pc_en),
    .clear (1'b0),
    .q     (hif.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hif.ifid_flush),
    .clear (1'b0),
    .q     (hif.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with BR_FLUSH_CYCLES=3 and 4-bit counters.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if #(.CNT_W(4)) hif ();

  hazard_ctrl #(.BR_FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
  logic [4:0] ctl;
  assign ctl = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_flush};

  localparam logic [4:0] C_ZERO  = 5'b00000;
  localparam logic [4:0] C_NORM  = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_BUBBL = 5'b00011;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs1_addr     = 5'd0;
    hif.id_rs2_addr     = 5'd0;
    hif.id_use_rs1      = 1'b0;
    hif.id_use_rs2      = 1'b0;
    hif.ex_rd_addr      = 5'd0;
    hif.ex_mem_read     = 1'b0;
    hif.ex_branch_taken = 1'b0;
    hif.imem_req        = 1'b0;
    hif.imem_ready      = 1'b1;
    hif.dmem_req        = 1'b0;
    hif.dmem_ready      = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    #2;
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_ZERO); end
    total++; if (hif.stall_cnt !== 4'd0 || hif.flush_cnt !== 4'd0) begin bad++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", hif.stall_cnt, hif.flush_cnt); end
    rst = 1'b1;
    #1;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL reset_release got=%b want=%b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd_addr = 5'd5; hif.id_rs1_addr = 5'd5; hif.id_use_rs1 = 1'b1;
    #2;
    total++; if (ctl !== C_BUBBL) begin bad++; $display("FAIL lu_bubble got=%b want=%b", ctl, C_BUBBL); end
    tick();
    hif.ex_mem_read = 1'b0;
    #2;
    total++; if (hif.stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", hif.stall_cnt); end
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL lu_after got=%b want=%b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_no_stall();
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd_addr = 5'd0; hif.id_rs1_addr = 5'd0; hif.id_use_rs1 = 1'b1;
    #2;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL x0_no_stall got=%b want=%b", ctl, C_NORM); end
    tick();
    hif.id_use_rs1 = 1'b0; hif.id_rs1_addr = 5'd3;
    hif.ex_rd_addr = 5'd7; hif.id_rs2_addr = 5'd7; hif.id_use_rs2 = 1'b0;
    #2;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL unused_rs2 got=%b want=%b", ctl, C_NORM); end
    tick();
    hif.id_use_rs2 = 1'b1;
    #2;
    total++; if (ctl !== C_BUBBL) begin bad++; $display("FAIL used_rs2 got=%b want=%b", ctl, C_BUBBL); end
    tick();
    idle_inputs();
    total++; if (hif.stall_cnt !== 4'd1) begin bad++; $display("FAIL no_stall_cnt got=%0d want=1", hif.stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    hif.ex_mem_read = 1'b1; hif.ex_rd_addr = 5'd9; hif.id_rs1_addr = 5'd9; hif.id_use_rs1 = 1'b1;
    hif.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL br_flush%0d got=%b want=%b", i, ctl, C_FLUSH); end
      tick();
      hif.ex_branch_taken = 1'b0;
    end
    idle_inputs();
    #2;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL br_done got=%b want=%b", ctl, C_NORM); end
    total++; if (hif.flush_cnt !== 4'd3 || hif.stall_cnt !== 4'd0) begin bad++;
      $display("FAIL br_cnts got=%0d/%0d want=3/0", hif.flush_cnt, hif.stall_cnt); end
    tick();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    hif.ex_branch_taken = 1'b1;
    tick();
    hif.ex_branch_taken = 1'b0;
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL freeze%0d got=%b want=%b", i, ctl, C_ZERO); end
      tick();
    end
    hif.dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++; if (ctl !== C_FLUSH) begin bad++; $display("FAIL resume%0d got=%b want=%b", i, ctl, C_FLUSH); end
      tick();
    end
    #2;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL freeze_done got=%b want=%b", ctl, C_NORM); end
    total++; if (hif.stall_cnt !== 4'd4 || hif.flush_cnt !== 4'd3) begin bad++;
      $display("FAIL freeze_cnts got=%0d/%0d want=4/3", hif.stall_cnt, hif.flush_cnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    hif.ex_branch_taken = 1'b1;
    tick();
    hif.ex_branch_taken = 1'b0;
    #1;
    total++; if (ctl !== C_FLUSH || hif.flush_cnt !== 4'd1) begin bad++;
      $display("FAIL ar_pre got=%b/%0d want=%b/1", ctl, hif.flush_cnt, C_FLUSH); end
    rst = 1'b0;
    #1;
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL ar_ctl got=%b want=%b", ctl, C_ZERO); end
    total++; if (hif.stall_cnt !== 4'd0 || hif.flush_cnt !== 4'd0) begin bad++;
      $display("FAIL ar_cnt got=%0d/%0d want=0/0", hif.stall_cnt, hif.flush_cnt); end
    tick();
    rst = 1'b1;
    #2;
    total++; if (ctl !== C_NORM) begin bad++; $display("FAIL ar_release got=%b want=%b", ctl, C_NORM); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    hif.imem_req = 1'b1; hif.imem_ready = 1'b0;
    repeat (20) tick();
    #2;
    total++; if (hif.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d want=15", hif.stall_cnt); end
    total++; if (ctl !== C_ZERO) begin bad++; $display("FAIL sat_ctl got=%b want=%b", ctl, C_ZERO); end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_freeze();
    test_async_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
